// File: rtl/quota_decoder_if.sv
// Handshake bundle for the stochastic-bitstream decoder: frame start, serial bit
// input, and the valid/ready result port.
interface quota_decoder_if #(
    parameter int BITSTREAM = 64,
    parameter int QUANT     = 8
);
    logic                          start;
    logic                          bit_valid;
    logic                          bit_in;
    logic                          busy;
    logic                          out_valid;
    logic                          out_ready;
    logic [QUANT-1:0]              data_out;
    logic [$clog2(BITSTREAM):0]    ones_count;

    modport master (
        output start, bit_valid, bit_in, out_ready,
        input  busy, out_valid, data_out, ones_count
    );

    modport slave (
        input  start, bit_valid, bit_in, out_ready,
        output busy, out_valid, data_out, ones_count
    );
endinterface

// File: rtl/quota_decoder.sv
// Counts the ones in a BITSTREAM-bit unipolar frame and converts the count back
// to a saturated signed QUANT-bit value, presented on a valid/ready handshake.
module quota_decoder #(
    parameter int BITSTREAM = 64,
    parameter int QUANT     = 8
) (
    input logic            clk,
    input logic            rst,
    quota_decoder_if.slave bus
);
    localparam int L  = $clog2(BITSTREAM);
    localparam int CW = L + 1;
    localparam int UW = QUANT + L + 2;

    localparam logic [CW-1:0]        LAST   = CW'(BITSTREAM - 1);
    localparam logic [UW-1:0]        HALF   = UW'(BITSTREAM / 2);
    localparam logic signed [UW-1:0] OFFSET = signed'(UW'(1) << (QUANT - 1));
    localparam logic signed [UW-1:0] MAXV   = OFFSET - signed'(UW'(1));
    localparam logic signed [UW-1:0] MINV   = -MAXV;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CW-1:0]          bit_cnt;
    logic [CW-1:0]          ones_cnt;
    logic [CW-1:0]          ones_final;
    logic                   accept;
    logic                   last_bit;
    logic [UW-1:0]          u;
    logic signed [UW-1:0]   q;
    logic [QUANT-1:0]       q_sat;
    logic [QUANT-1:0]       data_reg;
    logic [CW-1:0]          ones_reg;

    assign accept     = (state == ACCUM) && bus.bit_valid;
    assign last_bit   = accept && (bit_cnt == LAST);
    assign ones_final = ones_cnt + CW'(bus.bit_in);

    // Decode from the count including the bit being accepted, so the result
    // registers load on the same edge that takes the final bit.
    always_comb begin
        u     = ((UW'(ones_final) << QUANT) + HALF) >> L;
        q     = signed'(u) - OFFSET;
        q_sat = QUANT'(q);
        if (q > MAXV) begin
            q_sat = QUANT'(MAXV);
        end else if (q < MINV) begin
            q_sat = QUANT'(MINV);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start)     state_next = ACCUM;
            ACCUM:   if (last_bit)      state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            ones_cnt <= '0;
            data_reg <= '0;
            ones_reg <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                bit_cnt  <= '0;
                ones_cnt <= '0;
            end
            if (accept) begin
                bit_cnt  <= bit_cnt + CW'(1);
                ones_cnt <= ones_final;
            end
            if (last_bit) begin
                data_reg <= q_sat;
                ones_reg <= ones_final;
            end
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.data_out   = data_reg;
    assign bus.ones_count = ones_reg;
endmodule
